// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared 256-bit lc4_alu. It arbitrates round-robin,
// keeps a carry/float context per requester and buffers one response per requester.
module alu_arbiter #(
  parameter int WORD_SIZE = 256,
  parameter int INSN      = 19,
  parameter int IADDR     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [INSN:0]        req0_insn,
  input  logic [INSN:0]        req1_insn,
  input  logic [IADDR:0]       req0_pc,
  input  logic [IADDR:0]       req1_pc,
  input  logic [WORD_SIZE-1:0] req0_r1data,
  input  logic [WORD_SIZE-1:0] req0_r2data,
  input  logic [WORD_SIZE-1:0] req1_r1data,
  input  logic [WORD_SIZE-1:0] req1_r2data,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [WORD_SIZE-1:0] resp0_result,
  output logic [WORD_SIZE-1:0] resp1_result,
  input  logic                 ctx_we,
  input  logic                 ctx_sel,
  input  logic                 ctx_carry,
  input  logic [8:0]           ctx_float,
  output logic                 ctx0_carry,
  output logic                 ctx1_carry,
  output logic [8:0]           ctx0_float,
  output logic [8:0]           ctx1_float,
  output logic [INSN:0]        alu_insn,
  output logic [IADDR:0]       alu_pc,
  output logic [WORD_SIZE-1:0] alu_r1data,
  output logic [WORD_SIZE-1:0] alu_r2data,
  output logic                 alu_carry,
  output logic [8:0]           alu_float,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic                 alu_carry_out,
  input  logic [8:0]           alu_float_out
);

  // Handshake: a request transfers on an edge where req_valid[i] && req_ready[i];
  // a response transfers on an edge where resp_valid[i] && resp_ready[i].

  logic                 iss_valid;
  logic                 iss_id;
  logic [INSN:0]        iss_insn;
  logic [IADDR:0]       iss_pc;
  logic [WORD_SIZE-1:0] iss_r1;
  logic [WORD_SIZE-1:0] iss_r2;
  logic                 prio;

  logic [1:0]           carry_q;
  logic [8:0]           float_q [2];
  logic [WORD_SIZE-1:0] resp_q  [2];

  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] wb;
  logic [1:0] ctx_hit;
  logic       carry_op;
  logic [4:0] iss_op;

  // A requester with an op in flight is held off, so its next op always sees
  // the context already written back by the previous one.
  always_comb begin
    elig[0] = !rst && req_valid[0] && !(iss_valid && !iss_id)
              && (!resp_valid[0] || resp_ready[0]);
    elig[1] = !rst && req_valid[1] && !(iss_valid && iss_id)
              && (!resp_valid[1] || resp_ready[1]);
    grant = elig;
    if (elig == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = grant;

  assign wb[0]      = iss_valid && !iss_id;
  assign wb[1]      = iss_valid && iss_id;
  assign ctx_hit[0] = ctx_we && !ctx_sel;
  assign ctx_hit[1] = ctx_we && ctx_sel;

  assign iss_op = iss_insn[INSN -: 5];
  always_comb begin
    case (iss_op)
      5'b00101, 5'b00110, 5'b00111, 5'b10100, 5'b10101, 5'b10110: carry_op = 1'b1;
      default:                                                    carry_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_id    <= 1'b0;
      iss_insn  <= '0;
      iss_pc    <= '0;
      iss_r1    <= '0;
      iss_r2    <= '0;
      prio      <= 1'b0;
    end else if (grant != 2'b00) begin
      iss_valid <= 1'b1;
      iss_id    <= grant[1];
      iss_insn  <= grant[1] ? req1_insn   : req0_insn;
      iss_pc    <= grant[1] ? req1_pc     : req0_pc;
      iss_r1    <= grant[1] ? req1_r1data : req0_r1data;
      iss_r2    <= grant[1] ? req1_r2data : req0_r2data;
      prio      <= grant[0];
    end else begin
      iss_valid <= 1'b0;
    end
  end

  // Writeback beats a same-edge consume of the response buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 2'b00;
      resp_q[0]  <= '0;
      resp_q[1]  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wb[i]) begin
          resp_valid[i] <= 1'b1;
          resp_q[i]     <= alu_result;
        end else if (resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // A host context write overrides a colliding writeback for both fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q    <= 2'b00;
      float_q[0] <= '0;
      float_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ctx_hit[i]) begin
          carry_q[i] <= ctx_carry;
          float_q[i] <= ctx_float;
        end else if (wb[i]) begin
          float_q[i] <= alu_float_out;
          if (carry_op) begin
            carry_q[i] <= alu_carry_out;
          end
        end
      end
    end
  end

  assign alu_insn   = iss_valid ? iss_insn : '0;
  assign alu_pc     = iss_pc;
  assign alu_r1data = iss_r1;
  assign alu_r2data = iss_r2;
  assign alu_carry  = carry_q[iss_id];
  assign alu_float  = float_q[iss_id];

  assign resp0_result = resp_q[0];
  assign resp1_result = resp_q[1];
  assign ctx0_carry   = carry_q[0];
  assign ctx1_carry   = carry_q[1];
  assign ctx0_float   = float_q[0];
  assign ctx1_float   = float_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural lc4_alu stand-in, a context/result reference model
// and per-requester expected-result queues checked whenever a response is consumed.
module tb_alu_arbiter;
  localparam int W = 256;
  localparam logic [4:0] OP_ADD  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_XOR  = 5'b00001;
  localparam logic [4:0] OP_ADDC = 5'b10110;
  localparam logic [4:0] OP_DEC  = 5'b11000;

  typedef struct packed {
    logic         c;
    logic [8:0]   f;
    logic [W-1:0] r;
  } alu_out_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [19:0]  req0_insn = '0, req1_insn = '0;
  logic [10:0]  req0_pc = '0, req1_pc = '0;
  logic [W-1:0] req0_r1data = '0, req0_r2data = '0, req1_r1data = '0, req1_r2data = '0;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready = 2'b11;
  logic [W-1:0] resp0_result, resp1_result;
  logic         ctx_we = 1'b0, ctx_sel = 1'b0, ctx_carry = 1'b0;
  logic [8:0]   ctx_float = '0;
  logic         ctx0_carry, ctx1_carry;
  logic [8:0]   ctx0_float, ctx1_float;
  logic [19:0]  alu_insn;
  logic [10:0]  alu_pc;
  logic [W-1:0] alu_r1data, alu_r2data, alu_result;
  logic         alu_carry, alu_carry_out;
  logic [8:0]   alu_float, alu_float_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_insn(req0_insn), .req1_insn(req1_insn),
    .req0_pc(req0_pc), .req1_pc(req1_pc),
    .req0_r1data(req0_r1data), .req0_r2data(req0_r2data),
    .req1_r1data(req1_r1data), .req1_r2data(req1_r2data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp0_result(resp0_result), .resp1_result(resp1_result),
    .ctx_we(ctx_we), .ctx_sel(ctx_sel), .ctx_carry(ctx_carry), .ctx_float(ctx_float),
    .ctx0_carry(ctx0_carry), .ctx1_carry(ctx1_carry),
    .ctx0_float(ctx0_float), .ctx1_float(ctx1_float),
    .alu_insn(alu_insn), .alu_pc(alu_pc), .alu_r1data(alu_r1data), .alu_r2data(alu_r2data),
    .alu_carry(alu_carry), .alu_float(alu_float),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_float_out(alu_float_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU stand-in ----------------
  // Non-carry opcodes deliberately drive carry_out=1 so a wrongly updated carry shows up.
  function automatic alu_out_t alu_eval(input logic [19:0] insn, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic c, input logic [8:0] fl);
    alu_out_t o;
    o.c = 1'b1;
    o.f = fl;
    o.r = a ^ b;
    case (insn[19:15])
      5'b00101, 5'b10100, 5'b10101: {o.c, o.r} = {1'b0, a} + {1'b0, b};
      5'b00110: {o.c, o.r} = {1'b0, a} + {1'b0, ~b} + 257'd1;
      5'b00111: {o.c, o.r} = {1'b0, a} + {248'd0, insn[8:0]};
      5'b10110: {o.c, o.r} = {1'b0, a} + {1'b0, b} + {256'd0, c};
      5'b11000: begin
        o.f = fl - 9'd1;
        o.r = {247'd0, o.f};
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic is_carry_op(input logic [4:0] op);
    return op inside {5'b00101, 5'b00110, 5'b00111, 5'b10100, 5'b10101, 5'b10110};
  endfunction

  alu_out_t alu_o;
  always_comb alu_o = alu_eval(alu_insn, alu_r1data, alu_r2data, alu_carry, alu_float);
  assign alu_result    = alu_o.r;
  assign alu_carry_out = alu_o.c;
  assign alu_float_out = alu_o.f;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic         m_carry [2];
  logic [8:0]   m_float [2];
  bit           inf_valid = 1'b0;
  int           inf_id = 0;
  logic [19:0]  inf_insn;
  logic [W-1:0] inf_r1, inf_r2;

  always @(negedge clk) begin : mon
    alu_out_t m;
    logic     nc [2];
    logic [8:0] nf [2];
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      inf_valid = 1'b0;
      m_carry = '{default: 1'b0};
      m_float = '{default: 9'd0};
    end else begin
      check_eq("ctx0_carry", ctx0_carry, m_carry[0]);
      check_eq("ctx1_carry", ctx1_carry, m_carry[1]);
      check_eq("ctx0_float", ctx0_float, m_float[0]);
      check_eq("ctx1_float", ctx1_float, m_float[1]);
      if (resp_valid[0] && resp_ready[0]) begin
        if (exp_q0.size() == 0) check_eq("resp0_unexpected", resp_valid[0], 0);
        else check_eq("resp0_data", resp0_result, exp_q0.pop_front());
      end
      if (resp_valid[1] && resp_ready[1]) begin
        if (exp_q1.size() == 0) check_eq("resp1_unexpected", resp_valid[1], 0);
        else check_eq("resp1_data", resp1_result, exp_q1.pop_front());
      end
      nc = m_carry;
      nf = m_float;
      if (inf_valid) begin
        m = alu_eval(inf_insn, inf_r1, inf_r2, m_carry[inf_id], m_float[inf_id]);
        if (inf_id == 0) exp_q0.push_back(m.r);
        else exp_q1.push_back(m.r);
        nf[inf_id] = m.f;
        if (is_carry_op(inf_insn[19:15])) nc[inf_id] = m.c;
      end
      if (ctx_we) begin
        nc[ctx_sel] = ctx_carry;
        nf[ctx_sel] = ctx_float;
      end
      m_carry = nc;
      m_float = nf;
      inf_valid = 1'b0;
      if (req_valid[0] && req_ready[0]) begin
        inf_valid = 1'b1; inf_id = 0;
        inf_insn = req0_insn; inf_r1 = req0_r1data; inf_r2 = req0_r2data;
      end else if (req_valid[1] && req_ready[1]) begin
        inf_valid = 1'b1; inf_id = 1;
        inf_insn = req1_insn; inf_r1 = req1_r1data; inf_r2 = req1_r2data;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    ctx_we = 1'b0;
    resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    logic [19:0] insn;
    logic [10:0] pc;
    insn = {op, 15'($urandom_range(0, 32767))};
    pc   = 11'($urandom_range(0, 2047));
    if (id == 0) begin
      req0_insn = insn; req0_pc = pc; req0_r1data = a; req0_r2data = b;
    end else begin
      req1_insn = insn; req1_pc = pc; req1_r1data = a; req1_r2data = b;
    end
  endtask

  task automatic rand_req(input int id);
    logic [4:0] ops [4];
    ops = '{OP_ADD, OP_SUB, OP_XOR, OP_ADDC};
    set_req(id, ops[$urandom_range(0, 3)], {8{$urandom}}, {8{$urandom}});
  endtask

  // Returns one tick after the edge on which the request was accepted.
  task automatic issue(input int id, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bit done;
    done = 1'b0;
    set_req(id, op, a, b);
    req_valid[id] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (req_ready[id]) done = 1'b1;
    end
    if (!done) check_eq("issue_timeout", req_ready[id], 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  // ---------------- tests ----------------
  initial begin
    // reset state
    rst = 1'b1;
    req_valid = 2'b11;
    #12;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp0", resp0_result, 0);
    check_eq("rst_alu_insn", alu_insn, 0);
    check_eq("rst_alu_pc", alu_pc, 0);
    check_eq("rst_alu_r1", alu_r1data, 0);
    do_reset();

    // single ADD and its latency
    issue(0, OP_ADD, 5, 7);
    check_eq("t1_resp_pending", resp_valid[0], 0);
    idle(1);
    check_eq("t1_resp_valid", resp_valid[0], 1);
    check_eq("t1_result", resp0_result, 12);
    check_eq("t1_carry", ctx0_carry, 0);
    idle(3);

    // both requesters continuously valid: alternating grants
    do_reset();
    rand_req(0);
    rand_req(1);
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk);
      #1;
      rand_req(0);
      rand_req(1);
    end
    req_valid = 2'b00;
    idle(4);

    // carry chains kept separate per requester
    do_reset();
    issue(0, OP_ADD, '1, 1);
    idle(1);
    check_eq("t3_sum", resp0_result, 0);
    check_eq("t3_carry0", ctx0_carry, 1);
    fork
      issue(0, OP_ADDC, 0, 0);
      issue(1, OP_ADDC, 0, 0);
    join
    idle(1);
    check_eq("t3_addc0", resp0_result, 1);
    check_eq("t3_addc1", resp1_result, 0);
    idle(3);

    // held response blocks only requester 0
    do_reset();
    resp_ready = 2'b10;
    issue(0, OP_ADD, 1, 1);
    idle(1);
    check_eq("t4_hold_valid", resp_valid[0], 1);
    set_req(0, OP_ADD, 3, 4);
    rand_req(1);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("t4_blocked", req_ready[0], 0);
      check_eq("t4_req1_rate", req_ready[1], (k % 2 == 0) ? 1 : 0);
      @(posedge clk);
      #1 rand_req(1);
    end
    resp_ready = 2'b11;
    @(negedge clk);
    check_eq("t4_release", req_ready[0], 1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    idle(4);

    // float loop counter and context write collision
    do_reset();
    ctx_we = 1'b1; ctx_sel = 1'b1; ctx_float = 9'd3; ctx_carry = 1'b0;
    @(posedge clk);
    #1 ctx_we = 1'b0;
    check_eq("t5_float_load", ctx1_float, 3);
    for (int k = 0; k < 3; k++) begin
      issue(1, OP_DEC, 0, 0);
      idle(1);
      check_eq("t5_dec", resp1_result, 2 - k);
    end
    issue(1, OP_DEC, 0, 0);
    ctx_we = 1'b1; ctx_sel = 1'b1; ctx_float = 9'd7;
    @(posedge clk);
    #1 ctx_we = 1'b0;
    check_eq("t5_collide", ctx1_float, 7);
    check_eq("t5_iso", ctx0_float, 0);
    idle(3);

    // reset while an op is in flight
    do_reset();
    ctx_we = 1'b1; ctx_sel = 1'b0; ctx_float = 9'd5; ctx_carry = 1'b1;
    @(posedge clk);
    #1 ctx_we = 1'b0;
    set_req(0, OP_ADD, 9, 9);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("t6_grant", req_ready[0], 1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    #2 rst = 1'b1;
    #1;
    check_eq("t6_resp_valid", resp_valid, 0);
    check_eq("t6_ctx_carry", ctx0_carry, 0);
    check_eq("t6_ctx_float", ctx0_float, 0);
    check_eq("t6_alu_insn", alu_insn, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    check_eq("t6_no_late", resp_valid, 0);
    check_eq("t6_resp0", resp0_result, 0);
    rand_req(0);
    rand_req(1);
    req_valid = 2'b11;
    @(negedge clk);
    check_eq("t6_first_grant", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid = 2'b00;
    idle(5);

    check_eq("drain_q0", exp_q0.size(), 0);
    check_eq("drain_q1", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
